programmable_washing_machine: RTL and testbench

PROGRAMMABLE_WASHING_MACHINE -- requirements
Module: programmable_washing_machine

---
 rtl/programmable_washing_machine_pkg.sv | 40 ++++
 rtl/programmable_washing_machine_if.sv | 43 ++++
 rtl/wm_timer.sv | 43 ++++
 rtl/programmable_washing_machine.sv | 192 +++++++++++++++++++
 tb/tb_programmable_washing_machine.sv | 437 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/programmable_washing_machine_pkg.sv
// ---------------------------------------------------------------------------
// washer_pkg
//   Shared definitions for the programmable washing machine controller:
//   the 4-bit state encoding and small classification helpers used by the
//   controller FSM to decide which timer runs in which state.
// ---------------------------------------------------------------------------
package washer_pkg;

  typedef enum logic [3:0] {
    ST_IDLE        = 4'd0,
    ST_FILL        = 4'd1,
    ST_DETERGENT   = 4'd2,
    ST_WASH        = 4'd3,
    ST_DRAIN       = 4'd4,
    ST_RINSE_FILL  = 4'd5,
    ST_RINSE       = 4'd6,
    ST_SPIN        = 4'd7,
    ST_DONE        = 4'd8,
    ST_ABORT_DRAIN = 4'd9,
    ST_ERROR       = 4'd10
  } state_t;

  // States that belong to a running program; pause and abort act only here.
  // Relies on FILL..SPIN being encoded contiguously.
  function automatic logic in_program(state_t s);
    return (s >= ST_FILL) && (s <= ST_SPIN);
  endfunction

  // States whose duration is a fixed number of clocks (step timer runs).
  function automatic logic is_timed_step(state_t s);
    return (s == ST_WASH) || (s == ST_RINSE) || (s == ST_SPIN);
  endfunction

  // States that wait on a sensor and are guarded by the watchdog.
  function automatic logic is_watched(state_t s);
    return (s == ST_FILL) || (s == ST_DETERGENT) || (s == ST_DRAIN) ||
           (s == ST_RINSE_FILL) || (s == ST_ABORT_DRAIN);
  endfunction

endpackage

// File: rtl/programmable_washing_machine_if.sv
// ---------------------------------------------------------------------------
// programmable_washing_machine_if
//   Groups the washer's command inputs, sensor inputs and actuator/status
//   outputs into one bundle.
//   master : the environment (panel + sensors) - drives commands/sensors
//   slave  : the controller - drives actuators, door lock and status
// ---------------------------------------------------------------------------
interface programmable_washing_machine_if;

  // commands and sensors
  logic       start;
  logic       door_close;
  logic       pause;
  logic       abort;
  logic       filled;
  logic       detergent_added;
  logic       drained;

  // actuators and status
  logic       fill_valve_on;
  logic       detergent_valve_on;
  logic       motor_on;
  logic       drain_valve_on;
  logic       spin_motor_on;
  logic       door_lock;
  logic       done;
  logic       error;
  logic [3:0] state;
  logic [2:0] rinse_count;

  modport master (
    output start, door_close, pause, abort, filled, detergent_added, drained,
    input  fill_valve_on, detergent_valve_on, motor_on, drain_valve_on,
           spin_motor_on, door_lock, done, error, state, rinse_count
  );

  modport slave (
    input  start, door_close, pause, abort, filled, detergent_added, drained,
    output fill_valve_on, detergent_valve_on, motor_on, drain_valve_on,
           spin_motor_on, door_lock, done, error, state, rinse_count
  );

endinterface

// File: rtl/wm_timer.sv
// ---------------------------------------------------------------------------
// wm_timer
//   Loadable up-counter with synchronous clear, count enable and a
//   terminal-count compare.
//   clk        : clock, rising edge
//   rst_n      : asynchronous active-low reset (count -> 0)
//   i_clr      : synchronous clear, highest priority
//   i_load     : load i_load_val
//   i_load_val : value to load
//   i_en       : count enable
//   i_term     : terminal value to compare against
//   o_tc       : high while the count equals i_term
// ---------------------------------------------------------------------------
module wm_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_clr,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_en,
  input  logic [W-1:0] i_term,
  output logic         o_tc
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_en) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_tc = (r_count == i_term);

endmodule

// File: rtl/programmable_washing_machine.sv
// ---------------------------------------------------------------------------
// programmable_washing_machine
//   Washing machine program controller: fill, detergent, wash, NUM_RINSE
//   rinse passes (each with fill/rinse/drain), spin, done. Sensor-driven
//   steps are guarded by a watchdog that latches ERROR on timeout; abort
//   drains the tub and returns to IDLE; pause freezes the current step.
//   clk   : clock, rising edge
//   reset : asynchronous active-low reset
//   bus   : command/sensor inputs and actuator/status outputs (slave side)
// ---------------------------------------------------------------------------
module programmable_washing_machine
  import washer_pkg::*;
#(
  parameter int NUM_RINSE      = 2,
  parameter int WASH_CYCLES    = 64,
  parameter int RINSE_CYCLES   = 32,
  parameter int SPIN_CYCLES    = 48,
  parameter int TIMEOUT_CYCLES = 256,
  parameter int TIMER_W        = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  programmable_washing_machine_if.slave bus
);

  // Timers start at 0 on state entry, so a step of N clocks ends when the
  // count shows N-1 on the step's last clock.
  localparam logic [TIMER_W-1:0] WASH_TERM    = TIMER_W'(WASH_CYCLES - 1);
  localparam logic [TIMER_W-1:0] RINSE_TERM   = TIMER_W'(RINSE_CYCLES - 1);
  localparam logic [TIMER_W-1:0] SPIN_TERM    = TIMER_W'(SPIN_CYCLES - 1);
  localparam logic [TIMER_W-1:0] TIMEOUT_TERM = TIMER_W'(TIMEOUT_CYCLES - 1);
  localparam logic [2:0]         RINSE_LAST   = 3'(NUM_RINSE);

  state_t               r_state;
  state_t               w_next_state;
  logic [2:0]           r_rinse_count;
  logic                 w_hold;
  logic                 w_state_change;
  logic                 w_step_en;
  logic                 w_wd_en;
  logic                 w_step_tc;
  logic                 w_wd_tc;
  logic [TIMER_W-1:0]   w_step_term;

  logic w_fill, w_det, w_motor, w_drain, w_spin, w_lock, w_done, w_error;

  // Pause only freezes a running program; it never holds IDLE/DONE/ABORT/ERROR.
  assign w_hold         = in_program(r_state) && bus.pause;
  // Any state change restarts both timers so every state starts from zero.
  assign w_state_change = (w_next_state != r_state);
  assign w_step_en      = is_timed_step(r_state) && !w_hold;
  assign w_wd_en        = is_watched(r_state) && !w_hold;

  always_comb begin
    case (r_state)
      ST_WASH:  w_step_term = WASH_TERM;
      ST_RINSE: w_step_term = RINSE_TERM;
      default:  w_step_term = SPIN_TERM;
    endcase
  end

  wm_timer #(.W(TIMER_W)) u_step_timer (
    .clk        (clk),
    .rst_n      (reset),
    .i_clr      (w_state_change),
    .i_load     (1'b0),
    .i_load_val ('0),
    .i_en       (w_step_en),
    .i_term     (w_step_term),
    .o_tc       (w_step_tc)
  );

  wm_timer #(.W(TIMER_W)) u_watchdog (
    .clk        (clk),
    .rst_n      (reset),
    .i_clr      (w_state_change),
    .i_load     (1'b0),
    .i_load_val ('0),
    .i_en       (w_wd_en),
    .i_term     (TIMEOUT_TERM),
    .o_tc       (w_wd_tc)
  );

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic. Abort beats pause and step completion; within a
  // watched state the sensor is tested before the watchdog so a sensor
  // arriving on the timeout clock still wins.
  always_comb begin
    w_next_state = r_state;
    if (in_program(r_state) && bus.abort) begin
      w_next_state = ST_ABORT_DRAIN;
    end else if (!w_hold) begin
      case (r_state)
        ST_IDLE:
          if (bus.start && bus.door_close) w_next_state = ST_FILL;
        ST_FILL:
          if (bus.filled)       w_next_state = ST_DETERGENT;
          else if (w_wd_tc)     w_next_state = ST_ERROR;
        ST_DETERGENT:
          if (bus.detergent_added) w_next_state = ST_WASH;
          else if (w_wd_tc)        w_next_state = ST_ERROR;
        ST_WASH:
          if (w_step_tc)        w_next_state = ST_DRAIN;
        ST_DRAIN:
          if (bus.drained)      w_next_state = (r_rinse_count < RINSE_LAST) ? ST_RINSE_FILL : ST_SPIN;
          else if (w_wd_tc)     w_next_state = ST_ERROR;
        ST_RINSE_FILL:
          if (bus.filled)       w_next_state = ST_RINSE;
          else if (w_wd_tc)     w_next_state = ST_ERROR;
        ST_RINSE:
          if (w_step_tc)        w_next_state = ST_DRAIN;
        ST_SPIN:
          if (w_step_tc)        w_next_state = ST_DONE;
        ST_DONE:
          if (!bus.door_close)  w_next_state = ST_IDLE;
        ST_ABORT_DRAIN:
          if (bus.drained)      w_next_state = ST_IDLE;
          else if (w_wd_tc)     w_next_state = ST_ERROR;
        ST_ERROR:
          w_next_state = ST_ERROR;
        default:
          w_next_state = ST_IDLE;
      endcase
    end
  end

  // Completed rinse passes: bumped on RINSE exit, cleared at program start
  // and when an aborted program has drained.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rinse_count <= 3'd0;
    end else if (r_state == ST_IDLE && w_next_state == ST_FILL) begin
      r_rinse_count <= 3'd0;
    end else if (r_state == ST_ABORT_DRAIN && w_next_state == ST_IDLE) begin
      r_rinse_count <= 3'd0;
    end else if (r_state == ST_RINSE && w_next_state == ST_DRAIN) begin
      r_rinse_count <= r_rinse_count + 3'd1;
    end
  end

  // Moore output decode; pause masks the actuators but leaves the lock on.
  always_comb begin
    w_fill  = 1'b0;
    w_det   = 1'b0;
    w_motor = 1'b0;
    w_drain = 1'b0;
    w_spin  = 1'b0;
    w_done  = 1'b0;
    w_error = 1'b0;
    w_lock  = (r_state != ST_IDLE) && (r_state != ST_DONE);
    case (r_state)
      ST_FILL, ST_RINSE_FILL:            w_fill  = 1'b1;
      ST_DETERGENT:                      w_det   = 1'b1;
      ST_WASH, ST_RINSE:                 w_motor = 1'b1;
      ST_DRAIN, ST_ABORT_DRAIN:          w_drain = 1'b1;
      ST_SPIN:                           w_spin  = 1'b1;
      ST_DONE:                           w_done  = 1'b1;
      ST_ERROR: begin
        w_drain = 1'b1;
        w_error = 1'b1;
      end
      default: ;
    endcase
    if (w_hold) begin
      w_fill  = 1'b0;
      w_det   = 1'b0;
      w_motor = 1'b0;
      w_drain = 1'b0;
      w_spin  = 1'b0;
    end
  end

  assign bus.fill_valve_on      = w_fill;
  assign bus.detergent_valve_on = w_det;
  assign bus.motor_on           = w_motor;
  assign bus.drain_valve_on     = w_drain;
  assign bus.spin_motor_on      = w_spin;
  assign bus.door_lock          = w_lock;
  assign bus.done               = w_done;
  assign bus.error              = w_error;
  assign bus.state              = r_state;
  assign bus.rinse_count        = r_rinse_count;

endmodule

// File: tb/tb_programmable_washing_machine.sv
// ---------------------------------------------------------------------------
// tb_programmable_washing_machine
//   Directed self-checking bench for the washing machine controller with
//   NUM_RINSE=2, WASH=8, RINSE=4, SPIN=6, TIMEOUT=16.
// ---------------------------------------------------------------------------
module tb_programmable_washing_machine;
  import washer_pkg::*;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;
  logic [3:0] cur_s;
  logic [3:0] prev_s;
  int   cyc;

  programmable_washing_machine_if bus();

  programmable_washing_machine #(
    .NUM_RINSE      (2),
    .WASH_CYCLES    (8),
    .RINSE_CYCLES   (4),
    .SPIN_CYCLES    (6),
    .TIMEOUT_CYCLES (16),
    .TIMER_W        (16)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, got running expected finished");
    $fatal(1);
  end

  // {fill, detergent, motor, drain, spin, door_lock, done, error}
  function automatic logic [7:0] get_outs();
    return {bus.fill_valve_on, bus.detergent_valve_on, bus.motor_on,
            bus.drain_valve_on, bus.spin_motor_on, bus.door_lock,
            bus.done, bus.error};
  endfunction

  function automatic logic [7:0] exp_outs(logic [3:0] s);
    case (s)
      ST_FILL:        return 8'b1000_0100;
      ST_DETERGENT:   return 8'b0100_0100;
      ST_WASH:        return 8'b0010_0100;
      ST_DRAIN:       return 8'b0001_0100;
      ST_RINSE_FILL:  return 8'b1000_0100;
      ST_RINSE:       return 8'b0010_0100;
      ST_SPIN:        return 8'b0000_1100;
      ST_DONE:        return 8'b0000_0010;
      ST_ABORT_DRAIN: return 8'b0001_0100;
      ST_ERROR:       return 8'b0001_0101;
      default:        return 8'b0000_0000;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.start = 1'b0;
    bus.door_close = 1'b0;
    bus.pause = 1'b0;
    bus.abort = 1'b0;
    bus.filled = 1'b0;
    bus.detergent_added = 1'b0;
    bus.drained = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    prev_s = ST_IDLE;
    cyc = 0;
  endtask

  task automatic observe();
    cur_s = bus.state;
    if (cur_s != prev_s) cyc = 0;
    else cyc++;
    prev_s = cur_s;
  endtask

  // Sensors answer 2 cycles after the waiting state is entered.
  task automatic drive_sensors();
    bus.filled          = ((cur_s == ST_FILL) || (cur_s == ST_RINSE_FILL)) && (cyc == 2);
    bus.detergent_added = (cur_s == ST_DETERGENT) && (cyc == 2);
    bus.drained         = (cur_s == ST_DRAIN) && (cyc == 2);
  endtask

  task automatic start_program();
    bus.door_close = 1'b1;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (get_outs() !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_outs: got %b expected %b", get_outs(), 8'h00);
    end
    n_checks++;
    if (bus.state !== 4'd0 || bus.rinse_count !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_state: got state %0d rinse %0d expected 0 0", bus.state, bus.rinse_count);
    end
    reset = 1'b1;
    tick();
    n_checks++;
    if (bus.state !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_release: got state %0d expected 0", bus.state);
    end
    prev_s = ST_IDLE;
    cyc = 0;
    $display("test_reset: done");
  endtask

  task automatic test_nominal();
    logic [3:0] exp_seq [0:11];
    int seq_idx = 0;
    int wash_n = 0;
    int rinse_n = 0;
    int spin_n = 0;
    bit reached = 0;
    exp_seq = '{ST_FILL, ST_DETERGENT, ST_WASH, ST_DRAIN, ST_RINSE_FILL, ST_RINSE,
                ST_DRAIN, ST_RINSE_FILL, ST_RINSE, ST_DRAIN, ST_SPIN, ST_DONE};
    do_reset();
    start_program();
    for (int i = 0; i < 200 && !reached; i++) begin
      observe();
      if (cyc == 0) begin
        n_checks++;
        if (seq_idx > 11) begin
          n_fail++;
          $display("FAIL nominal_seq: got extra state %0d expected none", cur_s);
        end else if (cur_s !== exp_seq[seq_idx]) begin
          n_fail++;
          $display("FAIL nominal_seq[%0d]: got %0d expected %0d", seq_idx, cur_s, exp_seq[seq_idx]);
        end
        seq_idx++;
      end
      n_checks++;
      if (get_outs() !== exp_outs(cur_s)) begin
        n_fail++;
        $display("FAIL nominal_outs: state %0d got %b expected %b", cur_s, get_outs(), exp_outs(cur_s));
      end
      if (cur_s == ST_WASH)  wash_n++;
      if (cur_s == ST_RINSE) rinse_n++;
      if (cur_s == ST_SPIN)  spin_n++;
      if (cur_s == ST_DONE) reached = 1;
      else begin
        drive_sensors();
        tick();
      end
    end
    clear_inputs();
    bus.door_close = 1'b1;
    n_checks++;
    if (!reached) begin
      n_fail++;
      $display("FAIL nominal_done_reached: got state %0d expected %0d", cur_s, ST_DONE);
    end
    n_checks++;
    if (seq_idx != 12) begin
      n_fail++;
      $display("FAIL nominal_seq_len: got %0d expected 12", seq_idx);
    end
    n_checks++;
    if (wash_n != 8) begin
      n_fail++;
      $display("FAIL nominal_wash_clocks: got %0d expected 8", wash_n);
    end
    n_checks++;
    if (rinse_n != 8) begin
      n_fail++;
      $display("FAIL nominal_rinse_clocks: got %0d expected 8", rinse_n);
    end
    n_checks++;
    if (spin_n != 6) begin
      n_fail++;
      $display("FAIL nominal_spin_clocks: got %0d expected 6", spin_n);
    end
    n_checks++;
    if (bus.rinse_count !== 3'd2 || bus.done !== 1'b1 || bus.door_lock !== 1'b0) begin
      n_fail++;
      $display("FAIL nominal_final: got rinse %0d done %b lock %b expected 2 1 0",
               bus.rinse_count, bus.done, bus.door_lock);
    end
    tick();
    n_checks++;
    if (bus.state !== 4'(ST_DONE)) begin
      n_fail++;
      $display("FAIL nominal_done_hold: got %0d expected %0d", bus.state, ST_DONE);
    end
    bus.door_close = 1'b0;
    tick();
    n_checks++;
    if (bus.state !== 4'(ST_IDLE) || get_outs() !== 8'h00) begin
      n_fail++;
      $display("FAIL nominal_to_idle: got state %0d outs %b expected 0 00000000", bus.state, get_outs());
    end
    $display("test_nominal: %0d states, wash %0d rinse %0d spin %0d", seq_idx, wash_n, rinse_n, spin_n);
  endtask

  task automatic test_no_door();
    do_reset();
    bus.door_close = 1'b0;
    bus.start = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++;
      if (bus.state !== 4'd0 || get_outs() !== 8'h00) begin
        n_fail++;
        $display("FAIL no_door[%0d]: got state %0d outs %b expected 0 00000000", i, bus.state, get_outs());
      end
    end
    bus.start = 1'b0;
    $display("test_no_door: done");
  endtask

  task automatic test_pause();
    int wash_occ = 0;
    bit left_wash = 0;
    do_reset();
    start_program();
    for (int i = 0; i < 200 && !left_wash; i++) begin
      observe();
      if (cur_s == ST_WASH) begin
        wash_occ++;
        n_checks++;
        if (bus.pause) begin
          if (bus.motor_on !== 1'b0 || bus.door_lock !== 1'b1) begin
            n_fail++;
            $display("FAIL pause_outs[%0d]: got motor %b lock %b expected 0 1", wash_occ, bus.motor_on, bus.door_lock);
          end
        end else if (bus.motor_on !== 1'b1) begin
          n_fail++;
          $display("FAIL pause_motor_run[%0d]: got %b expected 1", wash_occ, bus.motor_on);
        end
        bus.pause = (wash_occ >= 3) && (wash_occ < 8);
      end
      if (cur_s == ST_DRAIN) left_wash = 1;
      drive_sensors();
      tick();
    end
    bus.pause = 1'b0;
    n_checks++;
    if (wash_occ != 13) begin
      n_fail++;
      $display("FAIL pause_wash_occupancy: got %0d expected 13", wash_occ);
    end
    $display("test_pause: wash occupancy %0d", wash_occ);
  endtask

  task automatic test_timeout();
    int fill_n = 0;
    do_reset();
    start_program();
    for (int i = 0; i < 40; i++) begin
      observe();
      if (cur_s != ST_FILL) break;
      fill_n++;
      tick();
    end
    n_checks++;
    if (fill_n != 16) begin
      n_fail++;
      $display("FAIL timeout_fill_clocks: got %0d expected 16", fill_n);
    end
    n_checks++;
    if (cur_s !== 4'(ST_ERROR) || get_outs() !== 8'b0001_0101) begin
      n_fail++;
      $display("FAIL timeout_error: got state %0d outs %b expected %0d 00010101", cur_s, get_outs(), ST_ERROR);
    end
    bus.filled = 1'b1;
    bus.drained = 1'b1;
    bus.start = 1'b1;
    bus.abort = 1'b1;
    repeat (4) tick();
    n_checks++;
    if (bus.state !== 4'(ST_ERROR) || bus.error !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_hold: got state %0d error %b expected %0d 1", bus.state, bus.error, ST_ERROR);
    end
    clear_inputs();
    $display("test_timeout: fill clocks %0d", fill_n);
  endtask

  task automatic test_sensor_race();
    int fill_n = 0;
    do_reset();
    start_program();
    for (int i = 0; i < 40; i++) begin
      observe();
      if (cur_s != ST_FILL) break;
      fill_n++;
      bus.filled = (fill_n == 16);
      tick();
    end
    bus.filled = 1'b0;
    n_checks++;
    if (cur_s !== 4'(ST_DETERGENT) || fill_n != 16) begin
      n_fail++;
      $display("FAIL sensor_race: got state %0d after %0d fill clocks expected %0d after 16",
               cur_s, fill_n, ST_DETERGENT);
    end
    $display("test_sensor_race: state %0d", cur_s);
  endtask

  task automatic test_abort();
    int rinse_entries = 0;
    bit found = 0;
    do_reset();
    start_program();
    for (int i = 0; i < 200 && !found; i++) begin
      observe();
      if (cur_s == ST_RINSE && cyc == 0) rinse_entries++;
      if (cur_s == ST_RINSE && cyc == 1 && rinse_entries == 2) found = 1;
      else begin
        drive_sensors();
        tick();
      end
    end
    n_checks++;
    if (!found || bus.rinse_count !== 3'd1) begin
      n_fail++;
      $display("FAIL abort_setup: got found %b rinse %0d expected 1 1", found, bus.rinse_count);
    end
    bus.pause = 1'b1;
    bus.abort = 1'b1;
    tick();
    bus.pause = 1'b0;
    bus.abort = 1'b0;
    n_checks++;
    if (bus.state !== 4'(ST_ABORT_DRAIN) || get_outs() !== 8'b0001_0100) begin
      n_fail++;
      $display("FAIL abort_enter: got state %0d outs %b expected %0d 00010100", bus.state, get_outs(), ST_ABORT_DRAIN);
    end
    tick();
    tick();
    n_checks++;
    if (bus.state !== 4'(ST_ABORT_DRAIN)) begin
      n_fail++;
      $display("FAIL abort_wait_drain: got %0d expected %0d", bus.state, ST_ABORT_DRAIN);
    end
    bus.drained = 1'b1;
    tick();
    bus.drained = 1'b0;
    n_checks++;
    if (bus.state !== 4'(ST_IDLE) || bus.rinse_count !== 3'd0 || get_outs() !== 8'h00) begin
      n_fail++;
      $display("FAIL abort_to_idle: got state %0d rinse %0d outs %b expected 0 0 00000000",
               bus.state, bus.rinse_count, get_outs());
    end
    $display("test_abort: done");
  endtask

  task automatic test_reset_spin();
    bit found = 0;
    do_reset();
    start_program();
    for (int i = 0; i < 200 && !found; i++) begin
      observe();
      if (cur_s == ST_SPIN && cyc == 2) found = 1;
      else begin
        drive_sensors();
        tick();
      end
    end
    n_checks++;
    if (!found || bus.spin_motor_on !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_spin_setup: got found %b spin %b expected 1 1", found, bus.spin_motor_on);
    end
    #2;
    reset = 1'b0;
    #1;
    n_checks++;
    if (get_outs() !== 8'h00 || bus.state !== 4'd0 || bus.rinse_count !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_spin_async: got outs %b state %0d rinse %0d expected 00000000 0 0",
               get_outs(), bus.state, bus.rinse_count);
    end
    tick();
    reset = 1'b1;
    prev_s = ST_IDLE;
    cyc = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (bus.state !== 4'd0 || get_outs() !== 8'h00) begin
        n_fail++;
        $display("FAIL reset_spin_no_drain[%0d]: got state %0d outs %b expected 0 00000000", i, bus.state, get_outs());
      end
    end
    $display("test_reset_spin: done");
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    reset = 1'b0;
    prev_s = ST_IDLE;
    cyc = 0;
    cur_s = ST_IDLE;
    clear_inputs();
    test_reset();
    test_nominal();
    test_no_door();
    test_pause();
    test_timeout();
    test_sensor_race();
    test_abort();
    test_reset_spin();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
